// File: rtl/axis_var_delay_pkt.sv
// Runtime-variable sample delay on one AXI-Stream with max-SPP re-packetisation.
// Define AXIS_VAR_DELAY_ZERO_FILL_EN to insert zeros instead of repeating the last sample.
module axis_var_delay_pkt #(
    parameter int MAX_LEN_LOG2   = 10,
    parameter int WIDTH          = 32,
    parameter int PRESERVE_TLAST = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [MAX_LEN_LOG2-1:0] len,
    input  logic [MAX_LEN_LOG2-1:0] max_spp,
    input  logic [WIDTH-1:0]        i_tdata,
    input  logic                    i_tlast,
    input  logic                    i_tvalid,
    output logic                    i_tready,
    output logic [WIDTH-1:0]        o_tdata,
    output logic                    o_tlast,
    output logic                    o_tvalid,
    input  logic                    o_tready,
    output logic [MAX_LEN_LOG2-1:0] cur_delay
);

    typedef enum logic [1:0] {
        S_WAIT,
        S_RUN,
        S_INSERT,
        S_DROP
    } state_t;

    localparam logic KEEP_LAST = (PRESERVE_TLAST != 0);
    localparam logic [MAX_LEN_LOG2-1:0] DLY_MAX = '1;
    localparam logic [MAX_LEN_LOG2-1:0] ONE = MAX_LEN_LOG2'(1);

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0]        hold;
    logic [WIDTH-1:0]        fill_data;
    logic [MAX_LEN_LOG2-1:0] spp_cnt;
    logic [MAX_LEN_LOG2-1:0] spp_lim;
    logic                    pending_last;

    logic load_en;
    logic accept;
    logic spp_last;
    logic pass_last;
    logic beat_last;
    logic emit_pass;
    logic emit_fill;
    logic drop_beat;
    logic dly_inc;
    logic dly_dec;

    assign load_en = !o_tvalid || o_tready;
    assign accept  = i_tvalid && i_tready;

    // >= rather than == so a lowered max_spp still closes the packet at once
    assign spp_lim   = max_spp - ONE;
    assign spp_last  = (max_spp != '0) && (spp_cnt >= spp_lim);
    assign pass_last = (KEEP_LAST && (i_tlast || pending_last)) || spp_last;
    assign beat_last = emit_pass ? pass_last : spp_last;

`ifdef AXIS_VAR_DELAY_ZERO_FILL_EN
    assign fill_data = hold & {WIDTH{1'b0}};
`else
    assign fill_data = hold;
`endif

    always_comb begin
        state_nxt = state;
        i_tready  = 1'b0;
        emit_pass = 1'b0;
        emit_fill = 1'b0;
        drop_beat = 1'b0;
        dly_inc   = 1'b0;
        dly_dec   = 1'b0;
        unique case (state)
            S_WAIT: begin
                i_tready = load_en;
                if (accept) begin
                    emit_pass = 1'b1;
                    state_nxt = (len > cur_delay) ? S_INSERT : S_RUN;
                end
            end
            S_RUN: begin
                i_tready = load_en;
                if (accept) begin
                    emit_pass = 1'b1;
                end else if (len > cur_delay) begin
                    state_nxt = S_INSERT;
                end else if (len < cur_delay) begin
                    state_nxt = S_DROP;
                end
            end
            S_INSERT: begin
                if (len <= cur_delay) begin
                    state_nxt = S_RUN;
                end else if (load_en) begin
                    emit_fill = 1'b1;
                    dly_inc   = 1'b1;
                end
            end
            S_DROP: begin
                // ready only while a drop is owed, so the exit cycle loses nothing
                i_tready = (len < cur_delay);
                if (len >= cur_delay) begin
                    state_nxt = S_RUN;
                end else if (i_tvalid) begin
                    drop_beat = 1'b1;
                    dly_dec   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_WAIT;
            o_tvalid     <= 1'b0;
            o_tdata      <= '0;
            o_tlast      <= 1'b0;
            cur_delay    <= '0;
            hold         <= '0;
            spp_cnt      <= '0;
            pending_last <= 1'b0;
        end else if (clear) begin
            state        <= S_WAIT;
            o_tvalid     <= 1'b0;
            o_tdata      <= '0;
            o_tlast      <= 1'b0;
            cur_delay    <= '0;
            hold         <= '0;
            spp_cnt      <= '0;
            pending_last <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_en) begin
                o_tvalid <= emit_pass || emit_fill;
                if (emit_pass) begin
                    o_tdata <= i_tdata;
                    o_tlast <= pass_last;
                end else if (emit_fill) begin
                    o_tdata <= fill_data;
                    o_tlast <= spp_last;
                end
            end
            if (emit_pass || drop_beat) begin
                hold <= i_tdata;
            end
            if (emit_pass || emit_fill) begin
                spp_cnt <= beat_last ? '0 : spp_cnt + ONE;
            end
            if (drop_beat && i_tlast && KEEP_LAST) begin
                pending_last <= 1'b1;
            end else if (emit_pass) begin
                pending_last <= 1'b0;
            end
            if (dly_inc && (cur_delay != DLY_MAX)) begin
                cur_delay <= cur_delay + ONE;
            end else if (dly_dec && (cur_delay != '0)) begin
                cur_delay <= cur_delay - ONE;
            end
        end
    end

endmodule
